// File: rtl/frame_logger.sv
// Snapshot logger: captures CHANNEL_COUNT fields plus IAGC status and streams them as one
// framed packet (binary or ASCII-hex) into a byte-wide uart_tx start/ready handshake.
module frame_logger #(
  parameter int unsigned IagcStatusSize = 4,
  parameter int unsigned ChannelCount   = 4,
  parameter int unsigned FieldSize      = 16,
  parameter int unsigned UartDataSize   = 8,
  parameter logic [7:0]  SyncByte       = 8'hA5,
  parameter int unsigned GuardCycles    = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               enable_i,
  input  logic                               valid_i,
  input  logic                               mode_i,
  input  logic [IagcStatusSize-1:0]          iagc_status_i,
  input  logic [ChannelCount*FieldSize-1:0]  fields_i,
  input  logic                               tx_ready_i,
  output logic [UartDataSize-1:0]            tx_data_o,
  output logic                               tx_valid_o,
  output logic                               busy_o,
  output logic [7:0]                         drop_count_o
);

  localparam int unsigned BytesPerField = FieldSize / 8;
  localparam int unsigned FieldBytes    = ChannelCount * BytesPerField;
  localparam int unsigned PayloadLen    = FieldBytes + 3;
  localparam int unsigned BinLen        = PayloadLen + 1;
  localparam int unsigned AsciiLen      = 2 * PayloadLen + 3;
  localparam int unsigned CntW          = $clog2(AsciiLen + 1);
  localparam int unsigned FselW         = (FieldBytes > 1) ? $clog2(FieldBytes) : 1;
  localparam int unsigned GuardW        = (GuardCycles > 1) ? $clog2(GuardCycles) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StGuard,
    StWaitRdy
  } state_e;

  state_e                    state_q;
  logic [CntW-1:0]           cnt_q;
  logic [GuardW-1:0]         gcnt_q;
  logic [7:0]                seq_q;
  logic [7:0]                csum_q;
  logic [7:0]                drop_q;
  logic                      busy_q;
  logic                      tx_valid_q;
  logic [UartDataSize-1:0]   tx_data_q;
  logic                      mode_q;
  logic [IagcStatusSize-1:0] status_q;
  logic [7:0]                fbyte_q  [FieldBytes];
  logic [7:0]                fbyte_in [FieldBytes];

  logic [CntW-1:0]  p_idx;
  logic [FselW-1:0] fsel;
  logic             hdr;
  logic             tail;
  logic             nib_lo;
  logic             last_byte;
  logic             frame_done;
  logic             csum_upd;
  logic [7:0]       status_ext;
  logic [7:0]       pbyte;
  logic [7:0]       next_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Flatten fields into emission order: field 0 first, each field MSB byte first.
  always_comb begin
    for (int f = 0; f < int'(ChannelCount); f++) begin
      for (int j = 0; j < int'(BytesPerField); j++) begin
        fbyte_in[f*BytesPerField + j] =
          fields_i[f*FieldSize + (BytesPerField - 1 - j)*8 +: 8];
      end
    end
  end

  always_comb begin
    hdr        = (cnt_q == '0);
    tail       = 1'b0;
    nib_lo     = 1'b1;
    p_idx      = cnt_q - CntW'(1);
    last_byte  = (cnt_q == CntW'(BinLen - 1));
    frame_done = (cnt_q == CntW'(BinLen));
    if (mode_q) begin
      // ASCII: odd counts carry the high nibble, even counts the low nibble.
      tail       = (cnt_q > CntW'(2 * PayloadLen));
      nib_lo     = ~cnt_q[0];
      p_idx      = (cnt_q - CntW'(1)) >> 1;
      last_byte  = (cnt_q == CntW'(AsciiLen - 1));
      frame_done = (cnt_q == CntW'(AsciiLen));
    end
    fsel = FselW'(p_idx - CntW'(2));

    status_ext                      = '0;
    status_ext[IagcStatusSize-1:0] = status_q;

    if (p_idx == '0) begin
      pbyte = seq_q;
    end else if (p_idx == CntW'(1)) begin
      pbyte = status_ext;
    end else if (p_idx == CntW'(PayloadLen - 1)) begin
      pbyte = csum_q;
    end else begin
      pbyte = fbyte_q[fsel];
    end

    if (!mode_q) begin
      next_byte = hdr ? SyncByte : pbyte;
    end else if (hdr) begin
      next_byte = 8'h24;
    end else if (tail) begin
      next_byte = (cnt_q == CntW'(2 * PayloadLen + 1)) ? 8'h0D : 8'h0A;
    end else begin
      next_byte = nib_lo ? hex_char(pbyte[3:0]) : hex_char(pbyte[7:4]);
    end

    // Fold a payload byte into the checksum once its last character goes out.
    csum_upd = !hdr && !tail && nib_lo && (p_idx != CntW'(PayloadLen - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      gcnt_q     <= '0;
      seq_q      <= '0;
      csum_q     <= '0;
      drop_q     <= '0;
      busy_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      mode_q     <= 1'b0;
      status_q   <= '0;
      for (int i = 0; i < int'(FieldBytes); i++) begin
        fbyte_q[i] <= '0;
      end
    end else begin
      tx_valid_q <= 1'b0;
      if (valid_i && enable_i && (state_q != StIdle) && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (valid_i && enable_i) begin
            mode_q   <= mode_i;
            status_q <= iagc_status_i;
            for (int i = 0; i < int'(FieldBytes); i++) begin
              fbyte_q[i] <= fbyte_in[i];
            end
            cnt_q   <= '0;
            csum_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: state_q <= StSend;
        StSend: begin
          if (tx_ready_i) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= next_byte;
            cnt_q      <= cnt_q + CntW'(1);
            if (csum_upd) begin
              csum_q <= csum_q ^ pbyte;
            end
            if (last_byte) begin
              seq_q <= seq_q + 8'd1;
            end
            gcnt_q  <= '0;
            state_q <= StGuard;
          end
        end
        StGuard: begin
          if (gcnt_q == GuardW'(GuardCycles - 1)) begin
            state_q <= StWaitRdy;
          end else begin
            gcnt_q <= gcnt_q + GuardW'(1);
          end
        end
        StWaitRdy: begin
          if (!frame_done) begin
            state_q <= StSend;
          end else if (tx_ready_i) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_data_o    = tx_data_q;
  assign tx_valid_o   = tx_valid_q;
  assign busy_o       = busy_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_frame_logger.sv
// Directed bench for frame_logger: table of hand-computed frames plus sequence, drop,
// enable, input-stability and mid-frame reset sequences against a simple uart_tx model.
module tb_frame_logger;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        valid;
  logic        mode;
  logic [3:0]  status;
  logic [63:0] fields;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic [7:0]  drop;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  int         hold       = 10;
  int         rdy_cnt    = 0;
  int         dbl_strobe = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] seq_exp    = 8'd0;

  always #5 clk = ~clk;

  frame_logger dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .valid_i       (valid),
    .mode_i        (mode),
    .iagc_status_i (status),
    .fields_i      (fields),
    .tx_ready_i    (tx_ready),
    .tx_data_o     (tx_data),
    .tx_valid_o    (tx_valid),
    .busy_o        (busy),
    .drop_count_o  (drop)
  );

  // uart_tx model: ready drops for `hold` cycles after each strobe.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rdy_cnt    = 0;
        prev_valid = 1'b0;
      end else begin
        if (tx_valid) begin
          if (prev_valid) dbl_strobe++;
          rx_q.push_back(tx_data);
          rdy_cnt = hold;
        end else if (rdy_cnt > 0) begin
          rdy_cnt--;
        end
        prev_valid = tx_valid;
      end
      tx_ready = (rdy_cnt == 0);
    end
  end

  typedef struct {
    logic        mode;
    logic        rst_before;
    logic [3:0]  status;
    logic [63:0] fields;
    int          len;
    logic [199:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic build_frame(input logic m, input logic [7:0] sq, input logic [3:0] st,
                             input logic [63:0] f, output logic [7:0] fb[0:31],
                             output int len);
    logic [7:0] p[0:10];
    logic [7:0] x;
    p[0] = sq;
    p[1] = {4'h0, st};
    for (int c = 0; c < 4; c++) begin
      p[2 + 2*c] = f[16*c + 8 +: 8];
      p[3 + 2*c] = f[16*c +: 8];
    end
    x = 8'h00;
    for (int i = 0; i < 10; i++) x ^= p[i];
    p[10] = x;
    for (int i = 0; i < 32; i++) fb[i] = 8'h00;
    if (!m) begin
      fb[0] = 8'hA5;
      for (int i = 0; i < 11; i++) fb[i + 1] = p[i];
      len = 12;
    end else begin
      fb[0] = 8'h24;
      for (int i = 0; i < 11; i++) begin
        fb[1 + 2*i] = hexc(p[i][7:4]);
        fb[2 + 2*i] = hexc(p[i][3:0]);
      end
      fb[23] = 8'h0D;
      fb[24] = 8'h0A;
      len = 25;
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] fb[0:31], input int len);
    int bad = -1;
    checks++;
    for (int i = 0; i < len && i < rx_q.size(); i++) begin
      if (bad < 0 && rx_q[i] !== fb[i]) bad = i;
    end
    if (rx_q.size() != len || bad >= 0) begin
      failures++;
      if (bad >= 0)
        $display("FAIL %s: %0d bytes (need %0d), byte %0d got %02h expected %02h",
                 name, rx_q.size(), len, bad, rx_q[bad], fb[bad]);
      else
        $display("FAIL %s: got %0d bytes expected %0d", name, rx_q.size(), len);
    end
  endtask

  // Caller is at a negedge; returns at the first negedge with busy low.
  task automatic run_frame(input logic m, input logic [3:0] st, input logic [63:0] f,
                           input bit scramble, input int pulses, output int issued);
    int  n      = 0;
    bit  toggle = 1'b1;
    issued = 0;
    rx_q.delete();
    mode   = m;
    status = st;
    fields = f;
    enable = 1'b1;
    valid  = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("busy_rise", {63'd0, busy}, 64'd1);
    while (busy && n < 5000) begin
      if (scramble) begin
        fields = {$urandom, $urandom};
        mode   = 1'($urandom);
        status = 4'($urandom);
      end
      if (issued < pulses && !toggle) begin
        valid = 1'b1;
        issued++;
      end else begin
        valid = 1'b0;
      end
      toggle = ~toggle;
      @(negedge clk);
      n++;
    end
    valid = 1'b0;
    check("frame_idle", {63'd0, busy}, 64'd0);
    seq_exp = seq_exp + 8'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    seq_exp = 8'd0;
  endtask

  initial begin
    logic [7:0]  fb[0:31];
    logic [63:0] f;
    logic [3:0]  st;
    int          len;
    int          issued;
    int          n;

    vecs[0] = '{1'b0, 1'b0, 4'h3, 64'hFFFF_0000_ABCD_1234, 12,
                200'hA5_00_03_12_34_AB_CD_00_00_FF_FF_43};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 64'hFFFF_0000_ABCD_1234, 25,
                "$00031234ABCD0000FFFF43\r\n"};
    vecs[2] = '{1'b0, 1'b0, 4'hF, 64'h7F00_8080_0203_0001, 12,
                200'hA5_01_0F_00_01_02_03_80_80_7F_00_71};
    vecs[3] = '{1'b1, 1'b0, 4'h0, 64'h7F00_8080_0203_0001, 25,
                "$02000001020380807F007D\r\n"};

    rst_n  = 1'b0;
    enable = 1'b0;
    valid  = 1'b0;
    mode   = 1'b0;
    status = 4'h0;
    fields = 64'h0;
    #1;
    check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_tx_data", {56'd0, tx_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_drop", {56'd0, drop}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].rst_before) do_reset();
      hold = 10;
      for (int i = 0; i < 32; i++) fb[i] = 8'h00;
      for (int i = 0; i < vecs[v].len; i++) fb[i] = vecs[v].exp[8*(vecs[v].len - 1 - i) +: 8];
      run_frame(vecs[v].mode, vecs[v].status, vecs[v].fields, 1'b0, 0, issued);
      check_frame($sformatf("vec%0d", v), fb, vecs[v].len);
    end

    // 257 back-to-back frames: sequence wraps, nothing dropped.
    do_reset();
    hold = 1;
    for (int i = 0; i < 257; i++) begin
      f  = {$urandom, $urandom};
      st = 4'($urandom);
      build_frame(1'b0, 8'(i), st, f, fb, len);
      run_frame(1'b0, st, f, 1'b0, 0, issued);
      check_frame($sformatf("seq%0d", i), fb, len);
    end
    check("b2b_no_drop", {56'd0, drop}, 64'd0);

    // valid with enable low: ignored entirely.
    rx_q.delete();
    enable = 1'b0;
    valid  = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (20) @(negedge clk);
    check("en_low_busy", {63'd0, busy}, 64'd0);
    check("en_low_bytes", 64'(rx_q.size()), 64'd0);
    check("en_low_drop", {56'd0, drop}, 64'd0);

    // Drops mid-frame, then saturation.
    hold = 60;
    f  = 64'h7F00_8080_0203_0001;
    build_frame(1'b0, seq_exp, 4'hF, f, fb, len);
    run_frame(1'b0, 4'hF, f, 1'b0, 3, issued);
    check_frame("drop3_frame", fb, len);
    check("drop3_count", {56'd0, drop}, 64'd3);
    build_frame(1'b1, seq_exp, 4'hF, f, fb, len);
    run_frame(1'b1, 4'hF, f, 1'b0, 300, issued);
    check_frame("drop_sat_frame", fb, len);
    check("drop_sat_count", {56'd0, drop}, 64'd255);

    // Inputs scrambled every cycle after capture.
    hold = 3;
    f  = 64'h1357_9BDF_2468_ACE0;
    build_frame(1'b1, seq_exp, 4'hA, f, fb, len);
    run_frame(1'b1, 4'hA, f, 1'b1, 0, issued);
    check_frame("stable_frame", fb, len);
    mode = 1'b0;

    // Reset at byte 5 of a frame.
    rx_q.delete();
    fields = 64'hFFFF_0000_ABCD_1234;
    status = 4'h3;
    mode   = 1'b0;
    enable = 1'b1;
    valid  = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while (rx_q.size() < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_byte5", {63'd0, rx_q.size() >= 5}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("mid_rst_tx_data", {56'd0, tx_data}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_drop", {56'd0, drop}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    seq_exp = 8'd0;
    for (int i = 0; i < 32; i++) fb[i] = 8'h00;
    for (int i = 0; i < 12; i++) fb[i] = vecs[0].exp[8*(11 - i) +: 8];
    run_frame(1'b0, 4'h3, 64'hFFFF_0000_ABCD_1234, 1'b0, 0, issued);
    check_frame("post_rst_frame", fb, 12);

    check("single_cycle_strobe", 64'(dbl_strobe), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
